dino_game_engine: RTL and testbench

Per-frame game-state engine that drives the position inputs of the VGA display controller and consumes that controller's frame-end and collision outputs. It advances the dino jump physics and the obstacle scroll once per video frame. It runs the game flow IDLE -> RUN -> OVER -> RUN and keeps a score. It sits between the player input (jump button) and the VGA controller.

---
 rtl/dino_game_engine.sv | 163 ++++++++++++++++
 tb/tb_dino_game_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_engine.sv
// dino_game_engine: per-frame dino jump / obstacle scroll / score engine.
// In: clk, reset(async low), screen_ready, collision_detected, jump_btn. Out: positions, score, game_over, running.
module dino_game_engine #(
  parameter int DINO_X       = 100,
  parameter int GROUND_Y     = 320,
  parameter int OBST_START_X = 680,
  parameter int JUMP_VEL     = 16,
  parameter int GRAVITY      = 1,
  parameter int SPEED_INIT   = 4,
  parameter int SPEED_STEP   = 8,
  parameter int SPEED_MAX    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_ready,
  input  logic        collision_detected,
  input  logic        jump_btn,
  output logic [31:0] x_coor,
  output logic [31:0] y_coor,
  output logic [31:0] x_coor_obstacle,
  output logic [31:0] y_coor_obstacle,
  output logic [15:0] score,
  output logic        game_over,
  output logic        running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OVER
  } state_e;

  localparam logic signed [12:0] GND13 = 13'(GROUND_Y);

  state_e             state_q, state_d;
  logic [11:0]        y_q, y_d;
  logic [11:0]        xo_q, xo_d;
  logic signed [7:0]  vel_q, vel_d;
  logic               air_q, air_d;
  logic [3:0]         speed_q, speed_d;
  logic [15:0]        score_q, score_d;
  logic               jreq_q, jreq_d;
  logic               sr_q;
  logic               js1_q, js2_q, js3_q;

  logic               tick;
  logic               jedge;
  logic               jump_now;
  logic signed [12:0] y_next;
  logic [15:0]        score_inc;

  assign tick      = screen_ready & ~sr_q;
  assign jedge     = js2_q & ~js3_q;
  // An edge arriving on the tick clock is used by that tick.
  assign jump_now  = jreq_q | jedge;
  assign y_next    = $signed({1'b0, y_q}) - {{5{vel_q[7]}}, vel_q};
  assign score_inc = score_q + 16'd1;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    xo_d    = xo_q;
    vel_d   = vel_q;
    air_d   = air_q;
    speed_d = speed_q;
    score_d = score_q;
    jreq_d  = jreq_q | jedge;
    if (tick) jreq_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        jreq_d = 1'b0;
        if (jedge) state_d = S_RUN;
      end
      S_RUN: begin
        if (tick) begin
          if (collision_detected) begin
            state_d = S_OVER;
          end else begin
            if (!air_q && jump_now) begin
              air_d = 1'b1;
              y_d   = y_q - 12'(JUMP_VEL);
              vel_d = 8'(JUMP_VEL - GRAVITY);
            end else if (air_q) begin
              if (y_next >= GND13) begin
                y_d   = 12'(GROUND_Y);
                vel_d = '0;
                air_d = 1'b0;
              end else begin
                y_d   = y_next[11:0];
                vel_d = vel_q - 8'(GRAVITY);
              end
            end
            if (xo_q <= {8'd0, speed_q}) begin
              xo_d    = 12'(OBST_START_X);
              score_d = score_inc;
              if (score_inc != 16'd0 &&
                  (score_inc % 16'(SPEED_STEP)) == 16'd0) begin
                if (speed_q >= 4'(SPEED_MAX))
                  speed_d = 4'(SPEED_MAX);
                else
                  speed_d = speed_q + 4'd1;
              end
            end else begin
              xo_d = xo_q - {8'd0, speed_q};
            end
          end
        end
      end
      S_OVER: begin
        jreq_d = 1'b0;
        if (jedge) begin
          y_d     = 12'(GROUND_Y);
          xo_d    = 12'(OBST_START_X);
          vel_d   = '0;
          air_d   = 1'b0;
          speed_d = 4'(SPEED_INIT);
          score_d = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      y_q     <= 12'(GROUND_Y);
      xo_q    <= 12'(OBST_START_X);
      vel_q   <= '0;
      air_q   <= 1'b0;
      speed_q <= 4'(SPEED_INIT);
      score_q <= '0;
      jreq_q  <= 1'b0;
      sr_q    <= 1'b0;
      js1_q   <= 1'b0;
      js2_q   <= 1'b0;
      js3_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      xo_q    <= xo_d;
      vel_q   <= vel_d;
      air_q   <= air_d;
      speed_q <= speed_d;
      score_q <= score_d;
      jreq_q  <= jreq_d;
      sr_q    <= screen_ready;
      js1_q   <= jump_btn;
      js2_q   <= js1_q;
      js3_q   <= js2_q;
    end
  end

  assign x_coor          = 32'(DINO_X);
  assign y_coor          = {20'd0, y_q};
  assign x_coor_obstacle = {20'd0, xo_q};
  assign y_coor_obstacle = 32'(GROUND_Y);
  assign score           = score_q;
  assign game_over       = (state_q == S_OVER);
  assign running         = (state_q == S_RUN);

endmodule

// File: tb/tb_dino_game_engine.sv
// tb_dino_game_engine: directed bench with a frame-level game model.
// Compares all outputs every cycle plus literal checkpoints.
module tb_dino_game_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        screen_ready = 1'b0;
  logic        collision_detected = 1'b0;
  logic        jump_btn = 1'b0;
  logic [31:0] x_coor, y_coor, x_coor_obstacle, y_coor_obstacle;
  logic [15:0] score;
  logic        game_over, running;

  dino_game_engine dut (
    .clk               (clk),
    .reset             (reset),
    .screen_ready      (screen_ready),
    .collision_detected(collision_detected),
    .jump_btn          (jump_btn),
    .x_coor            (x_coor),
    .y_coor            (y_coor),
    .x_coor_obstacle   (x_coor_obstacle),
    .y_coor_obstacle   (y_coor_obstacle),
    .score             (score),
    .game_over         (game_over),
    .running           (running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // game model: 0 idle, 1 run, 2 over
  int m_st, m_y, m_vel, m_air, m_xo, m_score, m_speed, m_jreq;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_y = 320; m_vel = 0; m_air = 0;
    m_xo = 680; m_score = 0; m_speed = 4; m_jreq = 0;
  endtask

  task automatic model_tick();
    int yn;
    if (m_st == 1) begin
      if (collision_detected) begin
        m_st = 2;
      end else begin
        if (m_air == 0 && m_jreq == 1) begin
          m_air = 1; m_y = m_y - 16; m_vel = 15;
        end else if (m_air == 1) begin
          yn = m_y - m_vel;
          if (yn >= 320) begin
            m_y = 320; m_vel = 0; m_air = 0;
          end else begin
            m_y = yn; m_vel = m_vel - 1;
          end
        end
        if (m_xo <= m_speed) begin
          m_xo = 680;
          m_score = (m_score + 1) % 65536;
          if (m_score != 0 && m_score % 8 == 0)
            m_speed = (m_speed + 1 > 12) ? 12 : m_speed + 1;
        end else begin
          m_xo = m_xo - m_speed;
        end
      end
    end
    m_jreq = 0;
  endtask

  task automatic model_press();
    if (m_st == 0) begin
      m_st = 1; m_jreq = 0;
    end else if (m_st == 2) begin
      m_y = 320; m_vel = 0; m_air = 0; m_xo = 680;
      m_speed = 4; m_score = 0; m_st = 1; m_jreq = 0;
    end else begin
      m_jreq = 1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("x_coor", x_coor, 32'd100);
      check("y_coor", y_coor, 32'(m_y));
      check("x_obs", x_coor_obstacle, 32'(m_xo));
      check("y_obs", y_coor_obstacle, 32'd320);
      check("score", {16'd0, score}, 32'(m_score));
      check("game_over", {31'd0, game_over}, 32'(m_st == 2));
      check("running", {31'd0, running}, 32'(m_st == 1));
    end
  end

  task automatic tick(int hold = 1);
    @(negedge clk) screen_ready = 1'b1;
    @(posedge clk) model_tick();
    repeat (hold - 1) @(posedge clk);
    @(negedge clk) screen_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    @(negedge clk) jump_btn = 1'b1;
    repeat (3) @(posedge clk);
    model_press();
    @(negedge clk) jump_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // edge detect lands on the same clk as the frame tick
  task automatic press_with_tick();
    @(negedge clk) jump_btn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) screen_ready = 1'b1;
    @(posedge clk) begin
      m_jreq = 1;
      model_tick();
    end
    @(negedge clk) begin
      screen_ready = 1'b0;
      jump_btn = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rst_x", x_coor, 32'd100);
    check("rst_y", y_coor, 32'd320);
    check("rst_xo", x_coor_obstacle, 32'd680);
    check("rst_score", {16'd0, score}, 32'd0);
    check("rst_run", {31'd0, running}, 32'd0);
    check("rst_over", {31'd0, game_over}, 32'd0);

    press();
    check("start_run", {31'd0, running}, 32'd1);
    tick(4);
    check("tick1_xo", x_coor_obstacle, 32'd676);
    check("tick1_y", y_coor, 32'd320);

    press();
    tick();
    check("jt1_y", y_coor, 32'd304);
    ticks(4);
    press();
    ticks(11);
    check("jt16_y", y_coor, 32'd184);
    tick();
    check("jt17_y", y_coor, 32'd184);
    ticks(16);
    check("jt33_y", y_coor, 32'd320);
    ticks(135);
    check("t169_xo", x_coor_obstacle, 32'd4);
    tick();
    check("t170_xo", x_coor_obstacle, 32'd680);
    check("t170_score", {16'd0, score}, 32'd1);

    n = 0;
    while (m_score < 8 && n < 2000) begin
      tick();
      n++;
    end
    check("score8_reached", {16'd0, score}, 32'd8);
    check("score8_xo", x_coor_obstacle, 32'd680);
    tick();
    check("speed5_xo", x_coor_obstacle, 32'd675);

    collision_detected = 1'b1;
    tick();
    collision_detected = 1'b0;
    check("coll_over", {31'd0, game_over}, 32'd1);
    check("coll_run", {31'd0, running}, 32'd0);
    ticks(10);
    check("frozen_xo", x_coor_obstacle, 32'd675);
    check("frozen_score", {16'd0, score}, 32'd8);
    press();
    check("restart_xo", x_coor_obstacle, 32'd680);
    check("restart_y", y_coor, 32'd320);
    check("restart_score", {16'd0, score}, 32'd0);
    check("restart_run", {31'd0, running}, 32'd1);

    press_with_tick();
    check("samejt_y", y_coor, 32'd304);
    ticks(4);
    check("mid_y", y_coor, 32'd250);

    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_y", y_coor, 32'd320);
    check("arst_xo", x_coor_obstacle, 32'd680);
    check("arst_score", {16'd0, score}, 32'd0);
    check("arst_run", {31'd0, running}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
